// File: rtl/access_controller_if.sv
// Access controller bus interface.
// Bundles the card-detector handshake, the whitelist write port and the
// controller status outputs.
//   master : card detector / host side (drives requests and writes)
//   slave  : access_controller side (drives unlock and status)
interface access_controller_if #(
  parameter int unsigned NUM_ENTRIES = 4
);
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic             start_auth;
  logic [31:0]      card_uid;
  logic             detection_error;
  logic             wl_we;
  logic [IDX_W-1:0] wl_idx;
  logic [31:0]      wl_uid;
  logic             wl_valid;

  logic             unlock;
  logic             auth_ok;
  logic             auth_fail;
  logic [IDX_W-1:0] match_idx;
  logic [7:0]       fail_count;
  logic             locked_out;
  logic             busy;

  modport master (
    output start_auth, card_uid, detection_error,
    output wl_we, wl_idx, wl_uid, wl_valid,
    input  unlock, auth_ok, auth_fail, match_idx, fail_count, locked_out, busy
  );

  modport slave (
    input  start_auth, card_uid, detection_error,
    input  wl_we, wl_idx, wl_uid, wl_valid,
    output unlock, auth_ok, auth_fail, match_idx, fail_count, locked_out, busy
  );
endinterface

// File: rtl/access_controller.sv
// Card access controller.
// Compares a presented card UID against a small whitelist, one slot per
// cycle, and either grants (timed unlock) or denies. Consecutive denials
// are counted and trigger a timed lockout.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - access_controller_if.slave (request, whitelist write, status)
//
// state   | meaning
// IDLE    | waiting for start_auth
// COMPARE | scanning whitelist slots, one per cycle
// GRANT   | unlock held for UNLOCK_CYCLES
// LOCKOUT | locked_out held for LOCKOUT_CYCLES
module access_controller #(
  parameter int unsigned NUM_ENTRIES    = 4,
  parameter int unsigned UNLOCK_CYCLES  = 1000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  access_controller_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    GRANT   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t           state;
  logic [31:0]      uid_q;
  logic [IDX_W-1:0] cmp_idx;
  logic [31:0]      timer;

  logic             unlock_q;
  logic             auth_ok_q;
  logic             auth_fail_q;
  logic [IDX_W-1:0] match_idx_q;
  logic [7:0]       fail_count_q;
  logic             locked_out_q;
  logic             busy_q;

  logic [31:0]            wl_uid_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] wl_valid_q;

  // Valid bits need reset; UID storage does not, its contents only matter
  // once the matching valid bit has been written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl_valid_q <= '0;
    end else if (bus.wl_we) begin
      wl_valid_q[bus.wl_idx] <= bus.wl_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wl_we) begin
      wl_uid_q[bus.wl_idx] <= bus.wl_uid;
    end
  end

  // Reads registered whitelist contents, so a write landing on the same edge
  // as a compare is not seen by that compare.
  logic       hit;
  logic       last_slot;
  logic [7:0] fail_next;

  assign hit       = wl_valid_q[cmp_idx] && (wl_uid_q[cmp_idx] == uid_q);
  assign last_slot = (cmp_idx == IDX_W'(NUM_ENTRIES - 1));
  assign fail_next = (fail_count_q == 8'hFF) ? 8'hFF : fail_count_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      uid_q        <= '0;
      cmp_idx      <= '0;
      timer        <= '0;
      unlock_q     <= 1'b0;
      auth_ok_q    <= 1'b0;
      auth_fail_q  <= 1'b0;
      match_idx_q  <= '0;
      fail_count_q <= '0;
      locked_out_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      auth_ok_q   <= 1'b0;
      auth_fail_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_auth) begin
            uid_q   <= bus.card_uid;
            cmp_idx <= '0;
            state   <= COMPARE;
            busy_q  <= 1'b1;
          end
        end
        COMPARE: begin
          if (bus.detection_error) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (hit) begin
            state        <= GRANT;
            match_idx_q  <= cmp_idx;
            fail_count_q <= '0;
            auth_ok_q    <= 1'b1;
            unlock_q     <= 1'b1;
            timer        <= UNLOCK_CYCLES - 1;
          end else if (last_slot) begin
            auth_fail_q  <= 1'b1;
            fail_count_q <= fail_next;
            if (32'(fail_next) >= MAX_FAILS) begin
              state        <= LOCKOUT;
              locked_out_q <= 1'b1;
              timer        <= LOCKOUT_CYCLES - 1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cmp_idx <= cmp_idx + IDX_W'(1);
          end
        end
        GRANT: begin
          if (timer == '0) begin
            state    <= IDLE;
            unlock_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state        <= IDLE;
            locked_out_q <= 1'b0;
            fail_count_q <= '0;
            busy_q       <= 1'b0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.unlock     = unlock_q;
  assign bus.auth_ok    = auth_ok_q;
  assign bus.auth_fail  = auth_fail_q;
  assign bus.match_idx  = match_idx_q;
  assign bus.fail_count = fail_count_q;
  assign bus.locked_out = locked_out_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_access_controller.sv
module tb_access_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  access_controller_if #(.NUM_ENTRIES(4)) bus ();

  access_controller #(
    .NUM_ENTRIES(4), .UNLOCK_CYCLES(8), .MAX_FAILS(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the last auth() window, cycle numbers relative to the
  // cycle in which start_auth was driven (cycle 0).
  int ok_n, fail_n, both_n, ok_cyc, fail_cyc;
  int unl_n, unl_first, lock_n, lock_first;
  logic [31:0] mi_at_ok, fc_at_ok, fc_at_fail;
  logic busy_at [64];

  task automatic auth(input logic [31:0] uid, input int n, input int err_cyc, input int wr_cyc);
    ok_n = 0; fail_n = 0; both_n = 0; ok_cyc = -1; fail_cyc = -1;
    unl_n = 0; unl_first = -1; lock_n = 0; lock_first = -1;
    mi_at_ok = '1; fc_at_ok = '1; fc_at_fail = '1;
    bus.start_auth = 1'b1;
    bus.card_uid   = uid;
    for (int c = 1; c <= n; c++) begin
      bus.detection_error = (c == err_cyc + 1);
      bus.wl_we           = (c == wr_cyc + 1);
      tick();
      bus.start_auth      = 1'b0;
      bus.detection_error = 1'b0;
      bus.wl_we           = 1'b0;
      busy_at[c] = bus.busy;
      if (bus.auth_ok && bus.auth_fail) both_n++;
      if (bus.auth_ok) begin
        ok_n++; ok_cyc = c;
        mi_at_ok = 32'(bus.match_idx); fc_at_ok = 32'(bus.fail_count);
      end
      if (bus.auth_fail) begin
        fail_n++; fail_cyc = c; fc_at_fail = 32'(bus.fail_count);
      end
      if (bus.unlock) begin
        unl_n++; if (unl_first < 0) unl_first = c;
      end
      if (bus.locked_out) begin
        lock_n++; if (lock_first < 0) lock_first = c;
      end
    end
  endtask

  task automatic wl_write(input logic [1:0] idx, input logic [31:0] uid, input logic v);
    bus.wl_we = 1'b1; bus.wl_idx = idx; bus.wl_uid = uid; bus.wl_valid = v;
    tick();
    bus.wl_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start_auth = 0; bus.card_uid = 0; bus.detection_error = 0;
    bus.wl_we = 0; bus.wl_idx = 0; bus.wl_uid = 0; bus.wl_valid = 0;
    #3;
    check("rst_unlock", 32'(bus.unlock), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_locked", 32'(bus.locked_out), 0);
    check("rst_fc", 32'(bus.fail_count), 0);
    check("rst_mi", 32'(bus.match_idx), 0);
    check("rst_pulses", 32'({bus.auth_ok, bus.auth_fail}), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Grant at slot 2
    wl_write(2, 32'hDEADBEEF, 1);
    auth(32'hDEADBEEF, 16, -1, -1);
    check("g_ok_n", 32'(ok_n), 1);
    check("g_ok_cyc", 32'(ok_cyc), 4);
    check("g_fail_n", 32'(fail_n), 0);
    check("g_mi", mi_at_ok, 2);
    check("g_unl_n", 32'(unl_n), 8);
    check("g_unl_first", 32'(unl_first), 4);
    check("g_busy_end", 32'(bus.busy), 0);

    // Empty whitelist, three denials into lockout
    wl_write(2, 32'hDEADBEEF, 0);
    auth(32'h12345678, 6, -1, -1);
    check("d1_cyc", 32'(fail_cyc), 5);
    check("d1_fc", fc_at_fail, 1);
    check("d1_lock", 32'(lock_n), 0);
    auth(32'h12345678, 6, -1, -1);
    check("d2_cyc", 32'(fail_cyc), 5);
    check("d2_fc", fc_at_fail, 2);
    auth(32'h12345678, 30, -1, -1);
    check("d3_cyc", 32'(fail_cyc), 5);
    check("d3_n", 32'(fail_n), 1);
    check("d3_fc", fc_at_fail, 3);
    check("lock_first", 32'(lock_first), 5);
    check("lock_n", 32'(lock_n), 16);
    check("lock_fc_clr", 32'(bus.fail_count), 0);
    check("d3_both", 32'(both_n), 0);

    // Two denials then a grant; start during GRANT ignored
    wl_write(2, 32'hDEADBEEF, 1);
    auth(32'h12345678, 6, -1, -1);
    auth(32'h12345678, 6, -1, -1);
    check("r_fc2", 32'(bus.fail_count), 2);
    check("r_nolock", 32'(lock_n), 0);
    auth(32'hDEADBEEF, 6, -1, -1);
    check("r_ok_cyc", 32'(ok_cyc), 4);
    check("r_fc_clr", fc_at_ok, 0);
    auth(32'hDEADBEEF, 20, -1, -1);
    check("ig_ok_n", 32'(ok_n), 0);
    check("ig_fail_n", 32'(fail_n), 0);
    check("ig_unl_n", 32'(unl_n), 5);

    // Detection error abort in cycle 2
    auth(32'h12345678, 6, -1, -1);
    check("a_pre_fc", 32'(bus.fail_count), 1);
    auth(32'h12345678, 10, 2, -1);
    check("a_busy1", 32'(busy_at[1]), 1);
    check("a_busy3", 32'(busy_at[3]), 0);
    check("a_pulses", 32'(ok_n + fail_n), 0);
    check("a_fc", 32'(bus.fail_count), 1);

    // Same-cycle write to the slot under compare uses old contents
    bus.wl_idx = 0; bus.wl_uid = 32'hCAFEF00D; bus.wl_valid = 1;
    auth(32'hCAFEF00D, 6, -1, 1);
    check("w_fail_cyc", 32'(fail_cyc), 5);
    check("w_ok_n", 32'(ok_n), 0);
    check("w_fc", fc_at_fail, 2);
    auth(32'hCAFEF00D, 5, -1, -1);
    check("w2_ok_cyc", 32'(ok_cyc), 2);
    check("w2_mi", mi_at_ok, 0);
    check("w2_fc", fc_at_ok, 0);
    check("w2_unlock", 32'(bus.unlock), 1);

    // Reset mid-GRANT
    rst = 1'b1;
    #1;
    check("mr_unlock", 32'(bus.unlock), 0);
    check("mr_busy", 32'(bus.busy), 0);
    check("mr_mi", 32'(bus.match_idx), 0);
    tick();
    rst = 1'b0;
    tick();
    auth(32'hCAFEF00D, 6, -1, -1);
    check("mr_inv0", 32'(fail_cyc), 5);
    check("mr_inv0_ok", 32'(ok_n), 0);
    auth(32'hDEADBEEF, 6, -1, -1);
    check("mr_inv2", 32'(fail_cyc), 5);
    check("mr_fc", fc_at_fail, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
